// File: rtl/scan_bist_ctrl.sv
// Scan/LBIST run controller: LFSR-driven scan-in patterns, MISR compaction
// of scan-out, and golden-signature compare at the end of each run.
module scan_bist_ctrl #(
  parameter int unsigned NUM_CHAINS = 7,
  parameter int unsigned CHAIN_LEN  = 32,
  parameter int unsigned PAT_W      = 16,
  parameter int unsigned MISR_W     = 32,
  parameter logic [31:0] MISR_POLY  = 32'h04C11DB7
) (
  input  logic                  CK,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PAT_W-1:0]      num_patterns,
  input  logic [31:0]           seed,
  input  logic [MISR_W-1:0]     expected,
  input  logic [NUM_CHAINS-1:0] so,
  output logic [NUM_CHAINS-1:0] si,
  output logic                  scan_en,
  output logic                  test_en,
  output logic                  busy,
  output logic                  done,
  output logic [MISR_W-1:0]     signature,
  output logic                  pass
);

  localparam int unsigned BIT_W = $clog2(CHAIN_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        lfsr, lfsr_d;
  logic [31:0]        seed_q;
  logic [PAT_W-1:0]   num_q;
  logic [PAT_W-1:0]   cnt, cnt_d;
  logic [BIT_W-1:0]   bit_cnt, bit_d;
  logic [MISR_W-1:0]  misr_d;
  logic               run_start;
  logic               run_abort;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [NUM_CHAINS-1:0] s);
    return {m[MISR_W-2:0], 1'b0}
         ^ (m[MISR_W-1] ? MISR_W'(MISR_POLY) : '0)
         ^ MISR_W'(s);
  endfunction

  assign run_start = (state == IDLE) && start && !abort;
  assign run_abort = (state != IDLE) && abort;

  // Next-state and next-datapath values; the register block below derives
  // every output from these so outputs track the state they belong to.
  always_comb begin
    state_nxt = state;
    lfsr_d    = lfsr;
    misr_d    = signature;
    cnt_d     = cnt;
    bit_d     = bit_cnt;
    case (state)
      IDLE: begin
        if (run_start) begin
          state_nxt = LOAD;
          misr_d    = '0;
          cnt_d     = '0;
        end
      end
      LOAD: begin
        lfsr_d    = (seed_q == 32'd0) ? 32'd1 : seed_q;
        bit_d     = '0;
        state_nxt = (num_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        lfsr_d = lfsr_step(lfsr);
        // First pattern's unload carries no captured response yet.
        if (cnt != '0) misr_d = misr_step(signature, so);
        bit_d = bit_cnt + BIT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          bit_d     = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        cnt_d     = cnt + PAT_W'(1);
        state_nxt = (cnt_d < num_q) ? SHIFT : UNLOAD;
      end
      UNLOAD: begin
        misr_d = misr_step(signature, so);
        bit_d  = bit_cnt + BIT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          bit_d     = '0;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (run_abort) begin
      state_nxt = IDLE;
      lfsr_d    = lfsr;
      misr_d    = signature;
      cnt_d     = cnt;
      bit_d     = '0;
    end
  end

  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= 32'd1;
      seed_q    <= '0;
      num_q     <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      signature <= '0;
      si        <= '0;
      scan_en   <= 1'b0;
      test_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_d;
      signature <= misr_d;
      if (run_start) begin
        num_q  <= num_patterns;
        seed_q <= seed;
      end
      busy    <= (state_nxt != IDLE);
      test_en <= (state_nxt != IDLE);
      scan_en <= (state_nxt == SHIFT) || (state_nxt == UNLOAD);
      si      <= (state_nxt == SHIFT) ? lfsr_d[NUM_CHAINS-1:0] : '0;
      done    <= (state_nxt == DONE);
      if (run_start || run_abort) pass <= 1'b0;
      else if (state_nxt == DONE) pass <= (misr_d == expected);
    end
  end

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed bench for scan_bist_ctrl; per-run expectations are queued at start
// and compared when the run leaves busy.
module tb_scan_bist_ctrl;
  localparam int unsigned NC = 7;
  localparam int unsigned CL = 4;
  localparam int unsigned PW = 3;
  localparam int unsigned MW = 32;

  logic          CK = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] num_patterns = '0;
  logic [31:0]   seed = '0;
  logic [MW-1:0] expected = '0;
  logic [NC-1:0] so = '0;
  logic [NC-1:0] si;
  logic          scan_en, test_en, busy, done, pass;
  logic [MW-1:0] signature;

  scan_bist_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .PAT_W(PW), .MISR_W(MW),
                   .MISR_POLY(32'h04C11DB7)) dut (
    .CK(CK), .rst_n(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .seed(seed), .expected(expected), .so(so),
    .si(si), .scan_en(scan_en), .test_en(test_en), .busy(busy), .done(done),
    .signature(signature), .pass(pass)
  );

  always #5 CK = ~CK;

  typedef struct {
    int          cycles;
    logic [63:0] se_mask;
    logic [31:0] sig;
    logic        pass_v;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  logic [NC-1:0] si_c2, si_c3;
  logic        done_seen;
  logic [31:0] sig_ref;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] misr_model(input int n_upd, input logic [NC-1:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n_upd; i++)
      m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ {25'b0, s};
    return m;
  endfunction

  function automatic logic [63:0] se_model(input int n);
    logic [63:0] m;
    m = '0;
    for (int p = 0; p < n; p++)
      for (int c = 0; c < int'(CL); c++) m[2 + p*(CL+1) + c] = 1'b1;
    if (n > 0)
      for (int c = 0; c < int'(CL); c++) m[2 + n*(CL+1) + c] = 1'b1;
    return m;
  endfunction

  // One full run: queue the expectation, drive it, observe, pop and compare.
  task automatic run(input int n, input logic [31:0] sd, input logic [NC-1:0] so_v,
                     input logic [31:0] exp_v, input int stray_start_at,
                     input bit release_rst, input string tag);
    exp_t e;
    int busy_cnt, done_at;
    logic [63:0] mask;
    bit seen_end;
    e.cycles  = (n == 0) ? 2 : 2 + n*(CL+1) + CL;
    e.se_mask = se_model(n);
    e.sig     = misr_model((n > 0) ? n*CL : 0, so_v);
    e.pass_v  = (e.sig == exp_v);
    sb.push_back(e);
    num_patterns = PW'(n);
    seed = sd;
    so = so_v;
    expected = exp_v;
    @(negedge CK);
    start = 1'b1;
    if (release_rst) rst_n = 1'b1;
    busy_cnt = 0; done_at = 0; mask = '0; seen_end = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CK);
      start = (k == stray_start_at);
      if (k == 2) si_c2 = si;
      if (k == 3) si_c3 = si;
      if (!busy) begin
        seen_end = 1'b1;
        break;
      end
      busy_cnt++;
      if (k < 64) mask[k] = scan_en;
      if (done) done_at = k;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, "_ended"},  64'(seen_end), 64'(1));
    check({tag, "_busy"},   64'(busy_cnt), 64'(e.cycles));
    check({tag, "_done"},   64'(done_at), 64'(e.cycles));
    check({tag, "_scanen"}, mask, e.se_mask);
    check({tag, "_sig"},    64'(signature), 64'(e.sig));
    check({tag, "_pass"},   64'(pass), 64'(e.pass_v));
  endtask

  initial begin
    #12;
    check("rst_si", 64'(si), 64'(0));
    check("rst_scan_en", 64'(scan_en), 64'(0));
    check("rst_test_en", 64'(test_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_sig", 64'(signature), 64'(0));

    // start on the first edge after reset release; all-zero response passes
    run(1, 32'h1234_5678, 7'h00, 32'h0, 0, 1'b1, "n1_zero");

    // zero seed substitutes 1; LFSR sequence 1 -> 3
    run(1, 32'h0, 7'h00, 32'h0, 0, 1'b0, "seed0");
    check("seed0_si_c2", 64'(si_c2), 64'(7'b0000001));
    check("seed0_si_c3", 64'(si_c3), 64'(7'b0000011));

    // three patterns, 12 MISR updates; one-bit-off golden fails, exact passes
    sig_ref = misr_model(12, 7'h01);
    run(3, 32'hBEEF, 7'h01, sig_ref ^ 32'h1, 0, 1'b0, "n3_bad");
    run(3, 32'hBEEF, 7'h01, sig_ref, 0, 1'b0, "n3_good");
    repeat (3) @(negedge CK);
    check("n3_sig_hold", 64'(signature), 64'(sig_ref));
    check("n3_pass_hold", 64'(pass), 64'(1));

    // zero patterns: LOAD then DONE, MISR cleared
    run(0, 32'h1, 7'h7F, 32'h0, 0, 1'b0, "n0");

    // maximum count with a stray start mid-run
    run(7, 32'hC0FFEE, 7'h55, 32'h0, 5, 1'b0, "nmax_stray");

    // abort in the third SHIFT cycle of pattern 2 (cycle 9)
    num_patterns = PW'(2); seed = 32'hACE1; so = 7'h01; expected = '0;
    @(negedge CK);
    start = 1'b1;
    done_seen = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CK);
      start = 1'b0;
      if (done) done_seen = 1'b1;
    end
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    if (done) done_seen = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_test_en", 64'(test_en), 64'(0));
    check("abort_scan_en", 64'(scan_en), 64'(0));
    check("abort_pass", 64'(pass), 64'(0));
    check("abort_sig", 64'(signature), 64'(misr_model(2, 7'h01)));
    repeat (2) begin
      @(negedge CK);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));
    run(1, 32'h77, 7'h00, 32'h0, 0, 1'b0, "post_abort");

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    @(negedge CK);
    start = 1'b0; abort = 1'b0;
    @(negedge CK);
    check("start_abort_idle", 64'(busy), 64'(0));

    // asynchronous reset in UNLOAD (cycle 8)
    num_patterns = PW'(1); seed = 32'h99; so = 7'h3C;
    @(negedge CK);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CK);
      start = 1'b0;
    end
    check("pre_rst_unload", 64'(scan_en), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 64'({si, scan_en, test_en, busy, done, pass}), 64'(0));
    check("mid_rst_sig", 64'(signature), 64'(0));
    @(negedge CK);
    check("mid_rst_no_done", 64'(done), 64'(0));
    run(1, 32'h5, 7'h00, 32'h0, 0, 1'b1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/scan_bist_ctrl.md
SCAN_BIST_CTRL -- requirements
Module: scan_bist_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_CHAINS, default 7: scan chain count, range 1..32.
- CHAIN_LEN, default 32: flops per chain, at least 2.
- PAT_W, default 16: pattern-count width.
- MISR_W, default 32: signature width, at least NUM_CHAINS.
- MISR_POLY, default 32'h04C11DB7: MISR feedback taps.

REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- CK, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a run; sampled in IDLE only.
- abort, in, 1: synchronous cancel of a run.
- num_patterns, in, PAT_W: pattern count; sampled with start.
- seed, in, 32: LFSR seed; sampled with start.
- expected, in, MISR_W: golden signature; compared in DONE.
- so, in, NUM_CHAINS: scan-out of each chain.
- si, out, NUM_CHAINS: scan-in to each chain.
- scan_en, out, 1: shift enable to the DUT.
- test_en, out, 1: DUT test mode, high while busy.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle end-of-run pulse.
- signature, out, MISR_W: MISR contents.
- pass, out, 1: signature==expected; valid from DONE until the next start.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, SHIFT, CAPTURE, UNLOAD and DONE.

REQ-004 IDLE with start=1 SHALL go to LOAD next cycle; this latches num_patterns and seed and clears the MISR and pattern counter.

REQ-005 LOAD SHALL last 1 cycle and load the LFSR with seed, substituting 32'h1 if seed==0.

REQ-006 From LOAD the FSM SHALL go to SHIFT if the latched count is non-zero, else to DONE.

REQ-007 SHIFT SHALL last exactly CHAIN_LEN cycles with scan_en=1 and si=lfsr[NUM_CHAINS-1:0], and the LFSR SHALL advance once per SHIFT cycle after si is driven.

REQ-008 The LFSR SHALL be Fibonacci, shifting left, with new bit0 = l[31]^l[21]^l[1]^l[0].

REQ-009 CAPTURE SHALL last 1 cycle with scan_en=0, si=0 and pattern counter +1.

REQ-010 After CAPTURE the FSM SHALL go to SHIFT if counter<latched count, else to UNLOAD.

REQ-011 UNLOAD SHALL last CHAIN_LEN cycles with scan_en=1 and si=0, then go to DONE.

REQ-012 The MISR SHALL update on every SHIFT cycle of pattern 2 onward and on every UNLOAD cycle, but never during pattern 1's SHIFT.

REQ-013 The MISR update SHALL be next = {m[MISR_W-2:0],1'b0} ^ (m[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended so.

REQ-014 DONE SHALL last 1 cycle with done=1, register pass, then return to IDLE.

REQ-015 signature and pass SHALL hold until the next start.

REQ-016 The run length SHALL be 2 + N*(CHAIN_LEN+1) + CHAIN_LEN cycles for N>0, and 2 cycles for N=0.

REQ-017 abort=1 in any busy state SHALL force IDLE next cycle, with done not pulsed, pass=0, and signature holding its last value; abort SHALL take priority over every other transition.

REQ-018 start while busy SHALL be ignored; start and abort together in IDLE SHALL leave the FSM in IDLE.

REQ-019 The pattern counter SHALL be PAT_W bits wide; num_patterns = 2^PAT_W-1 SHALL complete without wrap.

REQ-020 scan_en SHALL be 1 only in SHIFT and UNLOAD, and all outputs SHALL be registered.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state IDLE and set si=0, scan_en=0, test_en=0, busy=0, done=0, pass=0, signature=0, LFSR=1 and counter=0.

REQ-022 Reset asserted mid-run SHALL abandon the run with no done pulse.

REQ-023 After reset release the block SHALL accept start on the first rising edge.

Verification (NUM_CHAINS=7, CHAIN_LEN=4, MISR_W=32)
REQ-024 The bench SHALL cover these directed scenarios:
- num_patterns=1, so=0, expected=0 -> busy for 11 cycles; done pulses in cycle 11 after start; signature=0; pass=1.
- seed=0, num_patterns=1 -> first SHIFT cycle si=7'b0000001; scan_en high for cycles 2-5 and 7-10.
- num_patterns=0 -> LOAD then DONE; done in cycle 2; scan_en never high; signature=0.
- num_patterns=3, so held 7'h01 -> exactly 12 MISR updates; signature matches the bench model; expected off by one bit -> pass=0.
- abort in cycle 3 of SHIFT -> IDLE next cycle; no done; busy=0; a new start then runs normally.
- rst_n low mid-UNLOAD -> all outputs at reset values within the same cycle; start pulsed while busy -> no effect on cycle count.
